ha_chain_counter: RTL and testbench

- Parametrised synchronous modulo counter; next generation of the 4-bit counter project.
- Increment path is an explicit ripple chain of half-adder cells, generalised to WIDTH bits.
- Adds programmable modulus, synchronous clear and load, enable, terminal-count and registered wrap outputs.
- Used as the digit/prescaler building block for later display and timer projects.

---
 rtl/counter_pkg.sv | 21 ++
 rtl/ha_incrementer.sv | 38 +++
 rtl/ha_chain_counter.sv | 107 ++++++++++
 tb/tb_ha_chain_counter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the counter family.
//   MAX_WIDTH   : widest counter supported by the family
//   dir_e       : count direction (DIR_DOWN=0, DIR_UP=1)
//   term_value  : terminal count MOD_VALUE-1, masked to the counter width
package counter_pkg;

    localparam int MAX_WIDTH = 16;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    function automatic logic [MAX_WIDTH-1:0] term_value(input int width, input int mod_value);
        logic [MAX_WIDTH-1:0] mask;
        // At width == MAX_WIDTH the shift wraps to zero and the mask becomes all ones.
        mask = (MAX_WIDTH'(1) << width) - MAX_WIDTH'(1);
        return MAX_WIDTH'(mod_value - 1) & mask;
    endfunction

endpackage

// File: rtl/ha_incrementer.sv
// Ripple incrementer built from a chain of half-adder cells.
// Ports:
//   a     : input operand
//   sum   : a + 1 (modulo 2**WIDTH)
//   carry : carry out of the last cell
module ha_cell (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b;
    assign carry = a & b;
endmodule

module ha_incrementer #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);
    logic [WIDTH:0] chain;

    // The constant one enters as the b input of cell 0.
    assign chain[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        ha_cell u_cell (
            .a     (a[i]),
            .b     (chain[i]),
            .sum   (sum[i]),
            .carry (chain[i+1])
        );
    end

    assign carry = chain[WIDTH];
endmodule

// File: rtl/ha_chain_counter.sv
// Parametrised modulo counter with a half-adder ripple increment path.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   clr  : synchronous clear (highest priority)
//   load : synchronous load of d, saturated to MOD_VALUE-1
//   d    : load value
//   en   : count enable
//   dir  : 1=up, 0=down (only when HA_CHAIN_COUNTER_DOWN_EN is defined)
//   q    : registered count
//   tc   : combinational terminal count, high when this edge wraps
//   wrap : registered pulse, high in the cycle after a wrap
// Build option: define HA_CHAIN_COUNTER_DOWN_EN to add the dir port and down counting.
module ha_chain_counter
    import counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MOD_VALUE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
`ifdef HA_CHAIN_COUNTER_DOWN_EN
    input  logic             dir,
`endif
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $fatal(1, "ha_chain_counter: WIDTH %0d outside 1..%0d", WIDTH, MAX_WIDTH);
    end
    if (MOD_VALUE < 2 || MOD_VALUE > (1 << WIDTH)) begin : g_bad_mod
        $fatal(1, "ha_chain_counter: MOD_VALUE %0d outside 2..2**WIDTH", MOD_VALUE);
    end

    localparam logic [MAX_WIDTH-1:0] TERM_FULL = term_value(WIDTH, MOD_VALUE);
    localparam logic [WIDTH-1:0]     TERM      = TERM_FULL[WIDTH-1:0];

    logic             up;
    logic             at_term;
    logic [WIDTH-1:0] inc_a;
    logic [WIDTH-1:0] inc_sum;
    logic             carry_unused;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] wrap_val;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q_next;
    logic             wrap_next;

`ifdef HA_CHAIN_COUNTER_DOWN_EN
    assign up = (dir_e'(dir) == DIR_UP);
`else
    assign up = 1'b1;
`endif

    // Down counting reuses the incrementer: q-1 == ~(~q + 1).
    assign inc_a    = up ? q : ~q;
    assign step_val = up ? inc_sum : ~inc_sum;
    assign at_term  = up ? (q == TERM) : (q == '0);
    assign wrap_val = up ? '0 : TERM;
    assign load_val = (d > TERM) ? TERM : d;

    ha_incrementer #(
        .WIDTH (WIDTH)
    ) u_inc (
        .a     (inc_a),
        .sum   (inc_sum),
        .carry (carry_unused)
    );

    // Wrap is decided by the modulus compare, never by the chain carry.
    always_comb begin
        q_next    = q;
        wrap_next = 1'b0;
        if (clr) begin
            q_next = '0;
        end else if (load) begin
            q_next = load_val;
        end else if (en) begin
            if (at_term) begin
                q_next    = wrap_val;
                wrap_next = 1'b1;
            end else begin
                q_next = step_val;
            end
        end
    end

    // Gated by rst so tc drops immediately even when q==0 is the down-mode terminal.
    assign tc = ~rst & en & ~clr & ~load & at_term;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q    <= '0;
            wrap <= 1'b0;
        end else begin
            q    <= q_next;
            wrap <= wrap_next;
        end
    end

endmodule

// File: tb/tb_ha_chain_counter.sv
module tb_ha_chain_counter;

    localparam int MOD_A = 10;
    localparam int MOD_B = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       load;
    logic [3:0] d;
    logic       en;
`ifdef HA_CHAIN_COUNTER_DOWN_EN
    logic       dir;
`endif
    logic [3:0] q_a, q_b;
    logic       tc_a, tc_b, wrap_a, wrap_b;

    int n_checks = 0;
    int n_fail   = 0;

    // reference state, plain integers
    int m_qa = 0, m_wa = 0, m_qb = 0, m_wb = 0;

    ha_chain_counter #(.WIDTH(4), .MOD_VALUE(MOD_A)) u_dut_a (
        .clk (clk), .rst (rst), .clr (clr), .load (load), .d (d), .en (en),
`ifdef HA_CHAIN_COUNTER_DOWN_EN
        .dir (dir),
`endif
        .q (q_a), .tc (tc_a), .wrap (wrap_a)
    );

    ha_chain_counter #(.WIDTH(4), .MOD_VALUE(MOD_B)) u_dut_b (
        .clk (clk), .rst (rst), .clr (clr), .load (load), .d (d), .en (en),
`ifdef HA_CHAIN_COUNTER_DOWN_EN
        .dir (dir),
`endif
        .q (q_b), .tc (tc_b), .wrap (wrap_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int cur_up();
`ifdef HA_CHAIN_COUNTER_DOWN_EN
        return int'(dir);
`else
        return 1;
`endif
    endfunction

    function automatic int model_tc(input int mod, input int cq);
        int term;
        term = (cur_up() != 0) ? mod - 1 : 0;
        return (en && !clr && !load && cq == term) ? 1 : 0;
    endfunction

    task automatic model_edge(input int mod, inout int cq, output int cw);
        cw = 0;
        if (clr)
            cq = 0;
        else if (load)
            cq = (int'(d) > mod - 1) ? mod - 1 : int'(d);
        else if (en) begin
            if (cur_up() != 0) begin
                if (cq == mod - 1) begin cq = 0; cw = 1; end
                else cq = cq + 1;
            end else begin
                if (cq == 0) begin cq = mod - 1; cw = 1; end
                else cq = cq - 1;
            end
        end
    endtask

    // Apply inputs for one cycle, check tc before the edge and q/wrap after it.
    task automatic step(input string tag, input logic c, input logic l, input int dv, input logic e);
        clr  = c;
        load = l;
        d    = 4'(dv);
        en   = e;
        #1;
        check({tag, " tc_a"}, int'(tc_a), model_tc(MOD_A, m_qa));
        check({tag, " tc_b"}, int'(tc_b), model_tc(MOD_B, m_qb));
        @(posedge clk);
        model_edge(MOD_A, m_qa, m_wa);
        model_edge(MOD_B, m_qb, m_wb);
        #1;
        check({tag, " q_a"},    int'(q_a),    m_qa);
        check({tag, " wrap_a"}, int'(wrap_a), m_wa);
        check({tag, " q_b"},    int'(q_b),    m_qb);
        check({tag, " wrap_b"}, int'(wrap_b), m_wb);
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; load = 1'b0; d = '0; en = 1'b1;
`ifdef HA_CHAIN_COUNTER_DOWN_EN
        dir = 1'b1;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset q_a",    int'(q_a),    0);
        check("reset wrap_a", int'(wrap_a), 0);
        check("reset tc_a",   int'(tc_a),   0);
        check("reset q_b",    int'(q_b),    0);
        rst = 1'b0;

        // free count through a wrap: 1..9,0,1,2
        for (int i = 0; i < 12; i++) step("count", 1'b0, 1'b0, 0, 1'b1);
        check("count end q_a", int'(q_a), 2);

        // saturating load then wrap
        step("load5", 1'b0, 1'b1, 5, 1'b0);
        step("load_sat", 1'b0, 1'b1, 12, 1'b1);
        check("sat q_a", int'(q_a), 9);
        step("sat_wrap", 1'b0, 1'b0, 0, 1'b1);
        check("sat wrap_a", int'(wrap_a), 1);
        check("sat wrap q_a", int'(q_a), 0);

        // priority
        step("load7", 1'b0, 1'b1, 7, 1'b0);
        step("clr_prio", 1'b1, 1'b1, 3, 1'b1);
        check("clr_prio q_a", int'(q_a), 0);
        step("load7b", 1'b0, 1'b1, 7, 1'b0);
        step("load_prio", 1'b0, 1'b1, 3, 1'b1);
        check("load_prio q_a", int'(q_a), 3);

        // full-range modulus natural roll-over on the second instance
        step("load14", 1'b0, 1'b1, 14, 1'b0);
        step("to15", 1'b0, 1'b0, 0, 1'b1);
        check("q_b at 15", int'(q_b), 15);
        step("roll", 1'b0, 1'b0, 0, 1'b1);
        check("roll wrap_b", int'(wrap_b), 1);
        step("load15", 1'b0, 1'b1, 15, 1'b0);
        step("hold15", 1'b0, 1'b0, 0, 1'b0);
        check("hold q_b", int'(q_b), 15);

        // asynchronous reset between edges
        step("load6", 1'b0, 1'b1, 6, 1'b0);
        clr = 1'b0; load = 1'b0; en = 1'b1;
        #1 rst = 1'b1;
        #1;
        check("async q_a",    int'(q_a),    0);
        check("async wrap_a", int'(wrap_a), 0);
        check("async tc_a",   int'(tc_a),   0);
        check("async q_b",    int'(q_b),    0);
        #2 rst = 1'b0;
        m_qa = 0; m_wa = 0; m_qb = 0; m_wb = 0;
        step("after_rst", 1'b0, 1'b0, 0, 1'b1);
        check("after_rst q_a", int'(q_a), 1);

`ifdef HA_CHAIN_COUNTER_DOWN_EN
        dir = 1'b0;
        step("dn_load2", 1'b0, 1'b1, 2, 1'b0);
        for (int i = 0; i < 4; i++) step("dn", 1'b0, 1'b0, 0, 1'b1);
        check("dn end q_a", int'(q_a), 8);
        // tc must drop at once under reset even at q==0 in down mode
        step("dn_clr", 1'b1, 1'b0, 0, 1'b0);
        en = 1'b1;
        #1 rst = 1'b1;
        #1 check("dn rst tc_a", int'(tc_a), 0);
        #2 rst = 1'b0;
        m_qa = 0; m_wa = 0; m_qb = 0; m_wb = 0;
        dir = 1'b1;
`endif

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic rc, rl, re;
            int   rd;
            rc = ($urandom_range(0, 19) == 0);
            rl = ($urandom_range(0, 9) == 0);
            re = ($urandom_range(0, 3) != 0);
            rd = int'($urandom_range(0, 15));
`ifdef HA_CHAIN_COUNTER_DOWN_EN
            if ($urandom_range(0, 15) == 0) dir = ~dir;
`endif
            step("rand", rc, rl, rd, re);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
